// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the memory-stage controller:
//     - mem_state_t : FSM state encoding (IDLE=0, REQ=1, WAIT=2, RESP=3)
//     - ADDR_W_DEF, DATA_W_DEF, TMO_CYC_DEF : default widths and timeout length
//     - tmo_cnt_w() : width of a counter that must hold 0..TMO_CYC
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_t;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TMO_CYC_DEF = 15;

  function automatic int tmo_cnt_w(input int tmo_cyc);
    return $clog2(tmo_cyc + 1);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_tmo_ctr.sv
// -----------------------------------------------------------------------------
// mem_tmo_ctr
//   Saturating up-counter used to time out a memory access that never
//   completes. Counts 0..MAX and then holds at MAX.
// Ports
//   clk   in  clock
//   rst   in  asynchronous active-high reset, clears the count
//   clr   in  synchronous clear (priority over en)
//   en    in  count enable
//   last  out high while the count is one below MAX (or at MAX): the next
//             enabled cycle reaches the terminal count
// -----------------------------------------------------------------------------
module mem_tmo_ctr
  import mem_stage_pkg::*;
#(
  parameter int MAX   = TMO_CYC_DEF,
  parameter int CNT_W = tmo_cnt_w(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Increment that sticks at MAX so a long stall can never wrap back to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_V) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign last = (cnt >= LAST_V);

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Memory stage between execute and writeback. Accepts one instruction at a
//   time from execute, runs a multi-cycle data-memory access for loads and
//   stores (stall/done handshake), stalls execute while busy, and hands the
//   load data or the pass-through ALU result to writeback with a 1-cycle strobe.
//
// Configuration
//   ALIGN_CHECK_EN (define) : a load/store with ex_addr[0]=1 is rejected
//                             (err set, wb strobe with data 0, no access).
//                             Undefined: address bit 0 is not inspected.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   ex_valid/ex_memread/ex_memwrite/ex_addr/ex_wdata   instruction from execute
//   ex_ready                 high when an instruction can be accepted
//   mem_req/mem_wr/mem_addr/mem_wdata                  request to data memory
//   mem_stall/mem_done/mem_rdata                       response from data memory
//   wb_valid/wb_data         result strobe to writeback
//   err                      sticky error (illegal op, timeout, misalignment)
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ready,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  mem_state_t state;

  logic accept;
  logic is_mem;
  logic illegal_op;
  logic misaligned;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_last;

  assign ex_ready = (state == ST_IDLE) && !err;
  assign accept   = ex_valid && ex_ready;

  // The request is only presented while memory is not stalling, so the
  // cycle that shows mem_req is exactly the cycle the request is taken.
  assign mem_req  = (state == ST_REQ) && !mem_stall;

  assign is_mem     = ex_memread || ex_memwrite;
  assign illegal_op = ex_memread && ex_memwrite;

`ifdef ALIGN_CHECK_EN
  assign misaligned = ex_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  // Timeout counter restarts on the REQ->WAIT transition and runs in WAIT.
  assign tmo_clr = mem_req;
  assign tmo_en  = (state == ST_WAIT);

  mem_tmo_ctr #(
    .MAX (TMO_CYC)
  ) u_tmo_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .last (tmo_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        // ---- accept stage: decode and capture ----
        ST_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_data  <= DATA_W'(ex_addr);
            end else if (illegal_op || misaligned) begin
              err      <= 1'b1;
              wb_valid <= 1'b1;
              wb_data  <= '0;
            end else begin
              mem_wr    <= ex_memwrite;
              mem_addr  <= ex_addr;
              mem_wdata <= ex_wdata;
              state     <= ST_REQ;
            end
          end
        end
        // ---- request stage: wait out memory stall ----
        ST_REQ: begin
          if (!mem_stall) begin
            state <= ST_WAIT;
          end
        end
        // ---- wait stage: done wins over a coincident timeout ----
        ST_WAIT: begin
          if (mem_done) begin
            wb_data  <= mem_wr ? '0 : mem_rdata;
            wb_valid <= 1'b1;
            state    <= ST_RESP;
          end else if (tmo_last) begin
            err      <= 1'b1;
            wb_data  <= '0;
            wb_valid <= 1'b1;
            state    <= ST_RESP;
          end
        end
        // ---- response stage: wb strobe is high during this cycle ----
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_memread = 1'b0;
  logic          ex_memwrite = 1'b0;
  logic [AW-1:0] ex_addr = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic          ex_ready;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_stall = 1'b0;
  logic          mem_done = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic          err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TMO_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_memwrite(ex_memwrite),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_ready   (ex_ready),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .err        (err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } wb_exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  wb_exp_t  mon_wb;
  mem_exp_t mon_mem;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic err_m   = 1'b0;   // reference model's sticky error

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every mem_req and wb_valid must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mem_req_unexpected: got mem_req=1 addr %0h, expected no request (t=%0t)",
                   mem_addr, $time);
        end else begin
          mon_mem = mem_q.pop_front();
          chk("mem_wr", 32'(mem_wr), 32'(mon_mem.wr));
          chk("mem_addr", 32'(mem_addr), 32'(mon_mem.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(mon_mem.wdata));
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_valid_unexpected: got wb_valid=1 data %0h, expected no strobe (t=%0t)",
                   wb_data, $time);
        end else begin
          mon_wb = wb_q.pop_front();
          chk("wb_data", 32'(wb_data), 32'(mon_wb.data));
          chk("wb_err", 32'(err), 32'(mon_wb.err));
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ex_ready"},  32'(ex_ready),  32'd1);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_wr"},    32'(mem_wr),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
    chk({tag, "_wb_data"},   32'(wb_data),   32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  task automatic apply_reset();
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_stall = 1'b0;
    mem_done = 1'b0;
    wb_q.delete();
    mem_q.delete();
    err_m = 1'b0;
    #1;
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One instruction, including the memory side of the handshake.
  // wcyc = WAIT cycle in which mem_done is given (1..TMO); 0 = never.
  task automatic do_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int stall, input int wcyc,
                        input logic [DW-1:0] rdata);
    int       cnt;
    bit       mem_op;
    bit       bad;
    bit       timeout;
    wb_exp_t  we;
    mem_exp_t me;
    mem_op  = rd || wr;
    bad     = rd && wr;
`ifdef ALIGN_CHECK_EN
    if (mem_op && addr[0]) bad = 1'b1;
`endif
    timeout = (wcyc < 1) || (wcyc > TMO);

    ex_valid = 1'b1;
    ex_memread = rd;
    ex_memwrite = wr;
    ex_addr = addr;
    ex_wdata = wdata;
    cnt = 0;
    while (!ex_ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!ex_ready) begin
      chk("ex_ready_wait", 32'(ex_ready), 32'd1);
      ex_valid = 1'b0;
      return;
    end

    // Reference model: what writeback and memory should see for this op.
    if (!mem_op) begin
      we.data = DW'(addr);
    end else if (bad) begin
      err_m = 1'b1;
      we.data = '0;
    end else begin
      me.wr = wr;
      me.addr = addr;
      me.wdata = wdata;
      mem_q.push_back(me);
      if (timeout) begin
        err_m = 1'b1;
        we.data = '0;
      end else begin
        we.data = wr ? '0 : rdata;
      end
    end
    we.err = err_m;
    wb_q.push_back(we);

    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_memread = 1'($urandom);
    ex_memwrite = 1'($urandom);
    ex_addr = AW'($urandom);
    ex_wdata = DW'($urandom);
    if (!mem_op) return;
    if (bad) begin
      chk("err_after_reject", 32'(err), 32'd1);
      chk("ready_after_reject", 32'(ex_ready), 32'd0);
      return;
    end

    for (int i = 0; i < stall; i++) begin
      mem_stall = 1'b1;
      mem_done = 1'($urandom);
      chk("ready_low_req", 32'(ex_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_stall = 1'b0;
    mem_done = 1'($urandom);
    chk("ready_low_req", 32'(ex_ready), 32'd0);
    @(posedge clk);
    #1;
    mem_done = 1'b0;

    if (!timeout) begin
      for (int i = 1; i < wcyc; i++) begin
        mem_stall = 1'($urandom);
        mem_rdata = DW'($urandom);
        chk("ready_low_wait", 32'(ex_ready), 32'd0);
        chk("mem_addr_hold", 32'(mem_addr), 32'(addr));
        @(posedge clk);
        #1;
      end
      mem_done = 1'b1;
      mem_rdata = rdata;
      chk("mem_wdata_hold", 32'(mem_wdata), 32'(wdata));
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      mem_stall = 1'b0;
      mem_rdata = DW'($urandom);
      chk("ready_low_resp", 32'(ex_ready), 32'd0);
    end else begin
      for (int i = 1; i <= TMO; i++) begin
        mem_rdata = DW'($urandom);
        chk("err_before_tmo", 32'(err), 32'd0);
        @(posedge clk);
        #1;
      end
      chk("err_after_tmo", 32'(err), 32'd1);
      chk("ready_after_tmo", 32'(ex_ready), 32'd0);
    end
  endtask

  // After an error: execute keeps offering work, nothing may be accepted.
  task automatic check_locked(input string tag);
    ex_valid = 1'b1;
    ex_memread = 1'b0;
    ex_memwrite = 1'b0;
    ex_addr = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_ready_locked"}, 32'(ex_ready), 32'd0);
      chk({tag, "_err_sticky"}, 32'(err), 32'd1);
    end
    ex_valid = 1'b0;
  endtask

  initial begin : main
    int       r;
    int       cnt;
    logic [AW-1:0] a;
    mem_exp_t me;

    apply_reset();

    // Directed: pass-through, load, stalled store, boundary done at TMO.
    do_txn(1'b0, 1'b0, 16'h1234, 16'h0000, 0, 0, 16'h0000);
    do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 3, 16'hBEEF);
    do_txn(1'b0, 1'b1, 16'h0010, 16'hA5A5, 2, 2, 16'hFFFF);
    do_txn(1'b1, 1'b0, 16'h0022, 16'h0000, 1, TMO, 16'hC0DE);
    chk("no_err_done_at_tmo", 32'(err), 32'd0);
    // Back-to-back pass-through ops.
    do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 16'h0000);
    do_txn(1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0, 16'h0000);

    // Odd address load (rejected only when alignment checking is built in).
    do_txn(1'b1, 1'b0, 16'h0041, 16'h0000, 0, 2, 16'h5A5A);
    chk("err_odd_addr", 32'(err), 32'(err_m));
    apply_reset();

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 2);
      a = AW'($urandom);
`ifdef ALIGN_CHECK_EN
      if (r != 0) a[0] = 1'b0;
`endif
      do_txn(r == 1, r == 2, a, DW'($urandom), $urandom_range(0, 3),
             $urandom_range(1, TMO), DW'($urandom));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("err_clean_random", 32'(err), 32'd0);

    // Asynchronous reset in the middle of a load's WAIT phase.
    apply_reset();
    ex_valid = 1'b1;
    ex_memread = 1'b1;
    ex_memwrite = 1'b0;
    ex_addr = 16'h0080;
    ex_wdata = 16'h1111;
    me.wr = 1'b0;
    me.addr = 16'h0080;
    me.wdata = 16'h1111;
    mem_q.push_back(me);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    mem_stall = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    wb_q.delete();
    mem_q.delete();
    err_m = 1'b0;
    #1;
    check_reset_vals("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("ready_after_async", 32'(ex_ready), 32'd1);
    end

    // Timeout: memory never answers.
    do_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 0, 16'h0000);
    check_locked("tmo");
    apply_reset();

    // Both read and write requested: illegal.
    do_txn(1'b1, 1'b1, 16'h0200, 16'h2222, 0, 2, 16'h0000);
    check_locked("illegal");

    cnt = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0) && cnt < 50) begin
      @(posedge clk);
      cnt++;
    end
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
